// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the ID-stage decoder/hazard logic and the pipeline control unit.
interface pipe_ctrl_if #(
   parameter int unsigned OP_W = 4,
   parameter int unsigned FN_W = 4
);
   logic            id_valid;
   logic [OP_W-1:0] opcode;
   logic [FN_W-1:0] function_code;
   logic [1:0]      branch_result;
   logic            stall;
   logic            overflow_flag;

   logic       pc_op;
   logic       b_jmp;
   logic       pc_hold;
   logic       if_flush;
   logic       id_flush;
   logic       ex_flush;
   logic       r0_select;
   logic [1:0] ex_alu_op;
   logic [1:0] ex_mux_a;
   logic [1:0] ex_mux_b;
   logic       ex_valid;
   logic       mem_valid;
   logic       wb_valid;
   logic       mem_byte_en;
   logic       mem_write;
   logic       wb_mux_c;
   logic [1:0] wb_reg_write;
   logic [1:0] state;
   logic       halted;
   logic       overflow_error_warning;

   modport master (
      output id_valid, opcode, function_code, branch_result, stall, overflow_flag,
      input  pc_op, b_jmp, pc_hold, if_flush, id_flush, ex_flush, r0_select,
             ex_alu_op, ex_mux_a, ex_mux_b, ex_valid, mem_valid, wb_valid,
             mem_byte_en, mem_write, wb_mux_c, wb_reg_write, state, halted,
             overflow_error_warning
   );

   modport slave (
      input  id_valid, opcode, function_code, branch_result, stall, overflow_flag,
      output pc_op, b_jmp, pc_hold, if_flush, id_flush, ex_flush, r0_select,
             ex_alu_op, ex_mux_a, ex_mux_b, ex_valid, mem_valid, wb_valid,
             mem_byte_en, mem_write, wb_mux_c, wb_reg_write, state, halted,
             overflow_error_warning
   );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 16-bit 5-stage CPU: decode, stage control words, redirect, stall, halt drain.
// Optional sticky overflow trap enabled by defining OVF_TRAP_EN.
module pipe_ctrl_unit #(
   parameter int unsigned OP_W      = 4,
   parameter int unsigned FN_W      = 4,
   parameter int unsigned DRAIN_CYC = 3
) (
   input logic        clk,
   input logic        reset,
   pipe_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = 4;

   localparam logic [OP_W-1:0] OP_HALT  = OP_W'(4'b0000);
   localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(4'b0001);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(4'b0010);
   localparam logic [OP_W-1:0] OP_BR_GT = OP_W'(4'b0100);
   localparam logic [OP_W-1:0] OP_BR_LT = OP_W'(4'b0101);
   localparam logic [OP_W-1:0] OP_BR_EQ = OP_W'(4'b0110);
   localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4'b0111);
   localparam logic [OP_W-1:0] OP_LBU   = OP_W'(4'b1010);
   localparam logic [OP_W-1:0] OP_SB    = OP_W'(4'b1011);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(4'b1100);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(4'b1101);
   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(4'b1111);

   typedef enum logic [1:0] {
      S_RUN    = 2'b00,
      S_DRAIN  = 2'b01,
      S_HALTED = 2'b10,
      S_ERROR  = 2'b11
   } state_t;

   typedef struct packed {
      logic [1:0] alu_op;
      logic [1:0] mux_a;
      logic [1:0] mux_b;
      logic       mux_c;
      logic       byte_en;
      logic       mem_write;
      logic [1:0] reg_write;
   } ctrl_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halted_q;
   ctrl_t            dec;
   ctrl_t            ex_q;
   logic             ex_valid_q, mem_valid_q, wb_valid_q;
   logic             mem_byte_en_q, mem_write_q, mem_mux_c_q, wb_mux_c_q;
   logic [1:0]       mem_reg_write_q, wb_reg_write_q;
   logic             ovf_warn_q;
   logic             br_taken, ovf_trap, issue;
   logic             pc_op, b_jmp, pc_hold, if_flush, id_flush, ex_flush, r0_select;

   // ID-stage decode of opcode/function into the control word
   always_comb begin
      dec = '0;
      case (bus.opcode)
         OP_RTYPE: begin
            dec.alu_op = 2'b01;
            dec.mux_c  = 1'b1;
            if (bus.function_code == FN_W'(4'b1000) || bus.function_code == FN_W'(4'b0100))
               dec.reg_write = 2'b11;
            else if (bus.function_code == FN_W'(4'b0001) || bus.function_code == FN_W'(4'b0010))
               dec.reg_write = 2'b01;
         end
         OP_ANDI: dec = '{2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10};
         OP_ORI:  dec = '{2'b10, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10};
         OP_LBU:  dec = '{2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10};
         OP_SB:   dec = '{2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00};
         OP_LW:   dec = '{2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10};
         OP_SW:   dec = '{2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};
         default: dec = '0;
      endcase
   end

   assign br_taken = (bus.opcode == OP_BR_LT && bus.branch_result == 2'b11) ||
                     (bus.opcode == OP_BR_GT && bus.branch_result == 2'b10) ||
                     (bus.opcode == OP_BR_EQ && bus.branch_result == 2'b01);

`ifdef OVF_TRAP_EN
   assign ovf_trap = bus.overflow_flag & ex_valid_q & (state_q == S_RUN || state_q == S_DRAIN);
`else
   logic unused_ovf;
   assign unused_ovf = bus.overflow_flag;
   assign ovf_trap   = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_RUN;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         halted_q <= (state_d == S_HALTED) || (state_d == S_ERROR);
      end
   end

   // Next state and redirect/hold/flush outputs; priority overflow > halt > stall > branch/jmp
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      issue     = 1'b0;
      pc_op     = 1'b0;
      b_jmp     = 1'b0;
      pc_hold   = 1'b0;
      if_flush  = 1'b0;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      r0_select = 1'b0;
      if (ovf_trap) begin
         state_d  = S_ERROR;
         ex_flush = 1'b1;
         id_flush = 1'b1;
         if_flush = 1'b1;
         pc_hold  = 1'b1;
      end else begin
         case (state_q)
            S_RUN: begin
               if (bus.id_valid && bus.opcode == OP_HALT) begin
                  state_d  = S_DRAIN;
                  cnt_d    = '0;
                  issue    = 1'b1;
                  pc_hold  = 1'b1;
                  if_flush = 1'b1;
               end else if (bus.stall) begin
                  pc_hold = 1'b1;
               end else if (bus.id_valid) begin
                  if (br_taken) begin
                     pc_op     = 1'b1;
                     b_jmp     = 1'b1;
                     r0_select = 1'b1;
                     if_flush  = 1'b1;
                     id_flush  = 1'b1;
                  end else if (bus.opcode == OP_JMP) begin
                     pc_op    = 1'b1;
                     if_flush = 1'b1;
                     id_flush = 1'b1;
                  end else begin
                     issue = 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               pc_hold  = 1'b1;
               if_flush = 1'b1;
               if (cnt_q >= CNT_W'(DRAIN_CYC - 1)) state_d = S_HALTED;
               else cnt_d = cnt_q + CNT_W'(1);
            end
            default: pc_hold = 1'b1;
         endcase
      end
   end

   // Stage control registers; invalid stages carry an all-zero word
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_q            <= '0;
         ex_valid_q      <= 1'b0;
         mem_valid_q     <= 1'b0;
         mem_byte_en_q   <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_mux_c_q     <= 1'b0;
         mem_reg_write_q <= 2'b00;
         wb_valid_q      <= 1'b0;
         wb_mux_c_q      <= 1'b0;
         wb_reg_write_q  <= 2'b00;
         ovf_warn_q      <= 1'b0;
      end else begin
         ex_valid_q <= issue;
         ex_q       <= issue ? dec : '0;
         if (ex_valid_q && !ovf_trap) begin
            mem_valid_q     <= 1'b1;
            mem_byte_en_q   <= ex_q.byte_en;
            mem_write_q     <= ex_q.mem_write;
            mem_mux_c_q     <= ex_q.mux_c;
            mem_reg_write_q <= ex_q.reg_write;
         end else begin
            mem_valid_q     <= 1'b0;
            mem_byte_en_q   <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_mux_c_q     <= 1'b0;
            mem_reg_write_q <= 2'b00;
         end
         wb_valid_q     <= mem_valid_q;
         wb_mux_c_q     <= mem_mux_c_q;
         wb_reg_write_q <= mem_reg_write_q;
         if (ovf_trap) ovf_warn_q <= 1'b1;
      end
   end

   assign bus.pc_op        = pc_op;
   assign bus.b_jmp        = b_jmp;
   assign bus.pc_hold      = pc_hold;
   assign bus.if_flush     = if_flush;
   assign bus.id_flush     = id_flush;
   assign bus.ex_flush     = ex_flush;
   assign bus.r0_select    = r0_select;
   assign bus.ex_alu_op    = ex_q.alu_op;
   assign bus.ex_mux_a     = ex_q.mux_a;
   assign bus.ex_mux_b     = ex_q.mux_b;
   assign bus.ex_valid     = ex_valid_q;
   assign bus.mem_valid    = mem_valid_q;
   assign bus.mem_byte_en  = mem_byte_en_q;
   assign bus.mem_write    = mem_write_q;
   assign bus.wb_valid     = wb_valid_q;
   assign bus.wb_mux_c     = wb_mux_c_q;
   assign bus.wb_reg_write = wb_reg_write_q;
   assign bus.state        = state_q;
   assign bus.halted       = halted_q;
   assign bus.overflow_error_warning = ovf_warn_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode latency, branch/jmp redirect, stall, overflow trap, halt drain.
module tb_pipe_ctrl_unit;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   pipe_ctrl_if #(.OP_W(4), .FN_W(4)) bus ();

   pipe_ctrl_unit #(.OP_W(4), .FN_W(4), .DRAIN_CYC(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drv(input logic v, input logic [3:0] op, input logic [3:0] fn,
                      input logic [1:0] br, input logic st, input logic ov);
      bus.id_valid      = v;
      bus.opcode        = op;
      bus.function_code = fn;
      bus.branch_result = br;
      bus.stall         = st;
      bus.overflow_flag = ov;
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_state", 4'(bus.state), 4'd0);
      chk("rst_halted", 4'(bus.halted), 4'd0);
      chk("rst_ex_valid", 4'(bus.ex_valid), 4'd0);
      chk("rst_mem_valid", 4'(bus.mem_valid), 4'd0);
      chk("rst_wb_valid", 4'(bus.wb_valid), 4'd0);
      chk("rst_wb_reg_write", 4'(bus.wb_reg_write), 4'd0);
      chk("rst_ovf_warn", 4'(bus.overflow_error_warning), 4'd0);
      reset = 1'b1;

      // lw through EX, MEM, WB
      drv(1'b1, 4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("lw_pc_op", 4'(bus.pc_op), 4'd0);
      chk("lw_pc_hold", 4'(bus.pc_hold), 4'd0);
      tick();
      chk("lw_ex_valid", 4'(bus.ex_valid), 4'd1);
      chk("lw_ex_alu_op", 4'(bus.ex_alu_op), 4'd3);
      chk("lw_ex_mux_a", 4'(bus.ex_mux_a), 4'd3);
      chk("lw_ex_mux_b", 4'(bus.ex_mux_b), 4'd0);
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      tick();
      chk("lw_mem_valid", 4'(bus.mem_valid), 4'd1);
      chk("lw_mem_write", 4'(bus.mem_write), 4'd0);
      chk("lw_mem_byte_en", 4'(bus.mem_byte_en), 4'd0);
      chk("idle_ex_valid", 4'(bus.ex_valid), 4'd0);
      tick();
      chk("lw_wb_valid", 4'(bus.wb_valid), 4'd1);
      chk("lw_wb_reg_write", 4'(bus.wb_reg_write), 4'd2);
      chk("lw_wb_mux_c", 4'(bus.wb_mux_c), 4'd0);

      // back-to-back sb, R-type fn 0010, ori
      drv(1'b1, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0);
      tick();
      chk("sb_ex_alu_op", 4'(bus.ex_alu_op), 4'd3);
      chk("sb_ex_mux_a", 4'(bus.ex_mux_a), 4'd3);
      drv(1'b1, 4'b1111, 4'b0010, 2'b00, 1'b0, 1'b0);
      tick();
      chk("r_ex_alu_op", 4'(bus.ex_alu_op), 4'd1);
      chk("r_ex_mux_a", 4'(bus.ex_mux_a), 4'd0);
      chk("sb_mem_write", 4'(bus.mem_write), 4'd1);
      chk("sb_mem_byte_en", 4'(bus.mem_byte_en), 4'd1);
      drv(1'b1, 4'b0010, 4'b0000, 2'b00, 1'b0, 1'b0);
      tick();
      chk("ori_ex_alu_op", 4'(bus.ex_alu_op), 4'd2);
      chk("ori_ex_mux_b", 4'(bus.ex_mux_b), 4'd3);
      chk("r_mem_write", 4'(bus.mem_write), 4'd0);
      chk("sb_wb_reg_write", 4'(bus.wb_reg_write), 4'd0);
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      tick();
      chk("r_wb_reg_write", 4'(bus.wb_reg_write), 4'd1);
      chk("r_wb_mux_c", 4'(bus.wb_mux_c), 4'd1);
      tick();
      chk("ori_wb_reg_write", 4'(bus.wb_reg_write), 4'd2);
      chk("ori_wb_mux_c", 4'(bus.wb_mux_c), 4'd1);

      // taken beq, not-taken beq, taken blt, jmp
      drv(1'b1, 4'b0110, 4'b0000, 2'b01, 1'b0, 1'b0);
      chk("beq_pc_op", 4'(bus.pc_op), 4'd1);
      chk("beq_b_jmp", 4'(bus.b_jmp), 4'd1);
      chk("beq_r0_select", 4'(bus.r0_select), 4'd1);
      chk("beq_if_flush", 4'(bus.if_flush), 4'd1);
      chk("beq_id_flush", 4'(bus.id_flush), 4'd1);
      tick();
      chk("beq_ex_valid", 4'(bus.ex_valid), 4'd0);
      drv(1'b1, 4'b0110, 4'b0000, 2'b10, 1'b0, 1'b0);
      chk("beq_nt_pc_op", 4'(bus.pc_op), 4'd0);
      chk("beq_nt_if_flush", 4'(bus.if_flush), 4'd0);
      tick();
      chk("beq_nt_ex_valid", 4'(bus.ex_valid), 4'd1);
      chk("beq_nt_ex_alu_op", 4'(bus.ex_alu_op), 4'd0);
      drv(1'b1, 4'b0101, 4'b0000, 2'b11, 1'b0, 1'b0);
      chk("blt_pc_op", 4'(bus.pc_op), 4'd1);
      drv(1'b1, 4'b0111, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("jmp_pc_op", 4'(bus.pc_op), 4'd1);
      chk("jmp_b_jmp", 4'(bus.b_jmp), 4'd0);
      chk("jmp_id_flush", 4'(bus.id_flush), 4'd1);
      tick();
      chk("jmp_ex_valid", 4'(bus.ex_valid), 4'd0);

      // stall held behind a taken branch: no redirect
      drv(1'b1, 4'b0110, 4'b0000, 2'b01, 1'b1, 1'b0);
      chk("stall_br_pc_op", 4'(bus.pc_op), 4'd0);
      chk("stall_br_pc_hold", 4'(bus.pc_hold), 4'd1);

      // sw stalled two cycles
      drv(1'b1, 4'b1101, 4'b0000, 2'b00, 1'b1, 1'b0);
      chk("stall1_pc_hold", 4'(bus.pc_hold), 4'd1);
      tick();
      chk("stall1_ex_valid", 4'(bus.ex_valid), 4'd0);
      chk("stall2_pc_hold", 4'(bus.pc_hold), 4'd1);
      tick();
      chk("stall2_ex_valid", 4'(bus.ex_valid), 4'd0);
      drv(1'b1, 4'b1101, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("unstall_pc_hold", 4'(bus.pc_hold), 4'd0);
      tick();
      chk("sw_ex_valid", 4'(bus.ex_valid), 4'd1);
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      tick();
      chk("sw_mem_valid", 4'(bus.mem_valid), 4'd1);
      chk("sw_mem_write", 4'(bus.mem_write), 4'd1);
      tick();

      // overflow with R-type in EX
      drv(1'b1, 4'b1111, 4'b1000, 2'b00, 1'b0, 1'b0);
      tick();
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
`ifdef OVF_TRAP_EN
      chk("ovf_ex_flush", 4'(bus.ex_flush), 4'd1);
      chk("ovf_pc_hold", 4'(bus.pc_hold), 4'd1);
      tick();
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("ovf_mem_valid", 4'(bus.mem_valid), 4'd0);
      chk("ovf_state", 4'(bus.state), 4'd3);
      chk("ovf_warn", 4'(bus.overflow_error_warning), 4'd1);
      chk("ovf_halted", 4'(bus.halted), 4'd1);
      tick();
      chk("ovf_state_held", 4'(bus.state), 4'd3);
      chk("ovf_warn_held", 4'(bus.overflow_error_warning), 4'd1);
`else
      chk("ovf_ex_flush", 4'(bus.ex_flush), 4'd0);
      chk("ovf_pc_hold", 4'(bus.pc_hold), 4'd0);
      tick();
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("ovf_mem_valid", 4'(bus.mem_valid), 4'd1);
      chk("ovf_state", 4'(bus.state), 4'd0);
      chk("ovf_warn", 4'(bus.overflow_error_warning), 4'd0);
`endif
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("ovf_rst_state", 4'(bus.state), 4'd0);
      chk("ovf_rst_warn", 4'(bus.overflow_error_warning), 4'd0);
      chk("ovf_rst_wb_valid", 4'(bus.wb_valid), 4'd0);

      // overflow coinciding with a taken branch
      drv(1'b1, 4'b1111, 4'b0100, 2'b00, 1'b0, 1'b0);
      tick();
      drv(1'b1, 4'b0110, 4'b0000, 2'b01, 1'b0, 1'b1);
`ifdef OVF_TRAP_EN
      chk("ovf_br_pc_op", 4'(bus.pc_op), 4'd0);
      tick();
      chk("ovf_br_state", 4'(bus.state), 4'd3);
`else
      chk("ovf_br_pc_op", 4'(bus.pc_op), 4'd1);
      tick();
      chk("ovf_br_state", 4'(bus.state), 4'd0);
`endif
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;

      // halt drains DRAIN_CYC=3 cycles then halts
      drv(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      tick();
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("drain1_state", 4'(bus.state), 4'd1);
      chk("drain1_pc_hold", 4'(bus.pc_hold), 4'd1);
      chk("drain1_if_flush", 4'(bus.if_flush), 4'd1);
      tick();
      chk("drain2_state", 4'(bus.state), 4'd1);
      tick();
      chk("drain3_state", 4'(bus.state), 4'd1);
      chk("drain3_halted", 4'(bus.halted), 4'd0);
      tick();
      chk("halt_state", 4'(bus.state), 4'd2);
      chk("halt_halted", 4'(bus.halted), 4'd1);
      drv(1'b1, 4'b0111, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("halt_jmp_pc_op", 4'(bus.pc_op), 4'd0);
      drv(1'b1, 4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0);
      tick();
      chk("halt_ex_valid", 4'(bus.ex_valid), 4'd0);
      chk("halt_state_held", 4'(bus.state), 4'd2);
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("halt_rst_state", 4'(bus.state), 4'd0);
      chk("halt_rst_halted", 4'(bus.halted), 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
